// File: rtl/dmem_arb_pkg.sv
// Shared types for the data-memory arbiter.
// Struct field widths are sized by the package localparams below.
package dmem_arb_pkg;

  localparam int NUM_REQ     = 2;
  localparam int DMEM_ADDR_W = 32;
  localparam int DMEM_DATA_W = 32;

  typedef enum logic {
    IDLE,
    ACCESS
  } arb_state_e;

  typedef struct packed {
    logic                   we;
    logic [DMEM_ADDR_W-1:0] addr;
    logic [DMEM_DATA_W-1:0] wdata;
    logic [2:0]             func3;
  } dmem_req_t;

endpackage

// File: rtl/arb_pick.sv
// Two-input grant picker. DMEM_ARB_RR_EN selects round-robin on conflict;
// otherwise port 0 has fixed priority and the priority input is absent.
module arb_pick
  import dmem_arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] valid,
`ifdef DMEM_ARB_RR_EN
  input  logic               prio,
`endif
  output logic [NUM_REQ-1:0] grant
);

  always_comb begin
    grant = '0;
`ifdef DMEM_ARB_RR_EN
    if (valid == 2'b11) begin
      grant = prio ? 2'b10 : 2'b01;
    end else begin
      grant = valid;
    end
`else
    if (valid[0]) begin
      grant = 2'b01;
    end else if (valid[1]) begin
      grant = 2'b10;
    end
`endif
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares one data-memory port between the core (port 0) and a secondary master (port 1).
// Build with DMEM_ARB_RR_EN for round-robin arbitration; default is fixed priority to port 0.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W = DMEM_ADDR_W,
  parameter int DATA_W = DMEM_DATA_W
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ-1:0]        req_we,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
  input  logic [NUM_REQ*3-1:0]      req_func3,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]         rsp_rdata,
  output logic                      mem_read,
  output logic                      mem_write,
  output logic [ADDR_W-1:0]         mem_addr,
  output logic [DATA_W-1:0]         mem_wdata,
  output logic [2:0]                mem_func3,
  input  logic [DATA_W-1:0]         mem_rdata
);

  arb_state_e         state;
  dmem_req_t          req_q;
  dmem_req_t          win_req;
  logic               id_q;
  logic               win_id;
  logic               accept;
  logic               in_access;
  logic [NUM_REQ-1:0] grant;
`ifdef DMEM_ARB_RR_EN
  logic               prio_q;
`endif

  arb_pick u_pick (
    .valid (req_valid),
`ifdef DMEM_ARB_RR_EN
    .prio  (prio_q),
`endif
    .grant (grant)
  );

  assign req_ready = rst ? grant : '0;
  assign accept    = |req_ready;
  assign win_id    = grant[1];

  always_comb begin
    win_req.we    = req_we[win_id];
    win_req.addr  = DMEM_ADDR_W'(req_addr[int'(win_id)*ADDR_W +: ADDR_W]);
    win_req.wdata = DMEM_DATA_W'(req_wdata[int'(win_id)*DATA_W +: DATA_W]);
    win_req.func3 = req_func3[int'(win_id)*3 +: 3];
  end

  // req_q is cleared whenever nothing is accepted, so the mem_* buses read 0 in IDLE.
  assign in_access = (state == ACCESS);
  assign mem_read  = rst & in_access & ~req_q.we;
  assign mem_write = rst & in_access & req_q.we;
  assign mem_addr  = ADDR_W'(req_q.addr);
  assign mem_wdata = DATA_W'(req_q.wdata);
  assign mem_func3 = req_q.func3;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      req_q     <= '0;
      id_q      <= 1'b0;
      rsp_valid <= '0;
      rsp_rdata <= '0;
`ifdef DMEM_ARB_RR_EN
      prio_q    <= 1'b0;
`endif
    end else begin
      rsp_valid <= '0;
      if (in_access) begin
        rsp_valid[id_q] <= 1'b1;
        rsp_rdata       <= req_q.we ? '0 : mem_rdata;
      end
      if (accept) begin
        state <= ACCESS;
        req_q <= win_req;
        id_q  <= win_id;
`ifdef DMEM_ARB_RR_EN
        prio_q <= ~win_id;
`endif
      end else begin
        state <= IDLE;
        req_q <= '0;
      end
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: a transaction-queue model checked every cycle
// plus literal expectations for the key scenarios.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [1:0]  req_we;
  logic [63:0] req_addr;
  logic [63:0] req_wdata;
  logic [5:0]  req_func3;
  logic [1:0]  rsp_valid;
  logic [31:0] rsp_rdata;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [2:0]  mem_func3;
  logic [31:0] mem_rdata;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  dmem_arbiter dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_func3 (req_func3),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .mem_read  (mem_read),
    .mem_write (mem_write),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_func3 (mem_func3),
    .mem_rdata (mem_rdata)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Memory environment: combinational read, write on the rising edge.
  logic [31:0] mem [0:63];
  assign mem_rdata = mem[mem_addr[7:2]];

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 32'hA500_0000 | i;
    mem[4]  = 32'hDEAD_BEEF;
    mem[12] = 32'h0BAD_F00D;
    forever begin
      @(posedge clk);
      if (mem_write) mem[mem_addr[7:2]] <= mem_wdata;
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  // Reference model: accepted transactions tagged with their accept cycle.
  typedef struct {
    int          c;
    int          id;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [2:0]  f3;
    logic [31:0] rdata;
  } txn_t;

  txn_t        q[$];
  logic [31:0] exp_mem [0:63];
  int          last_grant;

  initial begin
    logic [1:0] exp_ready;
    int acc_i;
    int rsp_i;
    txn_t t;
    for (int i = 0; i < 64; i++) exp_mem[i] = 32'hA500_0000 | i;
    exp_mem[4]  = 32'hDEAD_BEEF;
    exp_mem[12] = 32'h0BAD_F00D;
    last_grant = 1;
    forever begin
      @(negedge clk);
      exp_ready = 2'b00;
      if (rst) begin
        if (req_valid == 2'b11) begin
`ifdef DMEM_ARB_RR_EN
          exp_ready = (last_grant == 0) ? 2'b10 : 2'b01;
`else
          exp_ready = 2'b01;
`endif
        end else begin
          exp_ready = req_valid;
        end
      end
      acc_i = -1;
      rsp_i = -1;
      foreach (q[i]) begin
        if (q[i].c == cyc - 1) acc_i = i;
        if (q[i].c == cyc - 2) rsp_i = i;
      end
      if (cyc >= 1) begin
        chk("m_ready", req_ready, exp_ready);
        if (acc_i >= 0) begin
          chk("m_read", mem_read, rst && !q[acc_i].we);
          chk("m_write", mem_write, rst && q[acc_i].we);
          if (rst) begin
            chk("m_addr", mem_addr, q[acc_i].addr);
            chk("m_func3", mem_func3, q[acc_i].f3);
            if (q[acc_i].we) chk("m_wdata", mem_wdata, q[acc_i].wdata);
          end
        end else begin
          chk("m_read_idle", mem_read, 0);
          chk("m_write_idle", mem_write, 0);
          if (rst) begin
            chk("m_addr_idle", mem_addr, 0);
            chk("m_wdata_idle", mem_wdata, 0);
            chk("m_func3_idle", mem_func3, 0);
          end
        end
        if (rsp_i >= 0) begin
          chk("m_rsp_valid", rsp_valid, 2'b01 << q[rsp_i].id);
          chk("m_rsp_rdata", rsp_rdata, q[rsp_i].rdata);
        end else begin
          chk("m_rsp_none", rsp_valid, 0);
        end
      end
      if (acc_i >= 0 && rst) begin
        if (q[acc_i].we) begin
          q[acc_i].rdata = 32'h0;
          exp_mem[q[acc_i].addr[7:2]] = q[acc_i].wdata;
        end else begin
          q[acc_i].rdata = exp_mem[q[acc_i].addr[7:2]];
        end
      end
      if (!rst) begin
        q.delete();
        last_grant = 1;
      end else begin
        if (exp_ready != 2'b00) begin
          t.c     = cyc;
          t.id    = exp_ready[1] ? 1 : 0;
          t.we    = req_we[t.id];
          t.addr  = req_addr[t.id*32 +: 32];
          t.wdata = req_wdata[t.id*32 +: 32];
          t.f3    = req_func3[t.id*3 +: 3];
          t.rdata = 32'h0;
          q.push_back(t);
          last_grant = t.id;
        end
        while (q.size() > 0 && q[0].c <= cyc - 2) void'(q.pop_front());
      end
    end
  end

  task automatic set_req(input int p, input logic v, input logic we, input logic [31:0] a,
                         input logic [31:0] d, input logic [2:0] f);
    req_valid[p]           = v;
    req_we[p]              = we;
    req_addr[p*32 +: 32]   = a;
    req_wdata[p*32 +: 32]  = d;
    req_func3[p*3 +: 3]    = f;
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    logic [1:0] exp_g;
    rst = 1'b0;
    req_valid = 2'b00; req_we = 2'b00; req_addr = '0; req_wdata = '0; req_func3 = '0;
    set_req(0, 1'b1, 1'b0, 32'h10, 32'h0, 3'b010);
    set_req(1, 1'b1, 1'b0, 32'h20, 32'h0, 3'b010);
    step(2);
    chk("reset_ready", req_ready, 2'b00);
    chk("reset_rsp_valid", rsp_valid, 2'b00);
    chk("reset_strobes", {mem_read, mem_write}, 2'b00);
    rst = 1'b1;
    req_valid = 2'b00;
    step(1);

    // Single load from port 0.
    set_req(0, 1'b1, 1'b0, 32'h10, 32'h0, 3'b010);
    #1 chk("load_ready", req_ready, 2'b01);
    step(1);
    req_valid = 2'b00;
    #1 chk("load_mem_read", {mem_read, mem_write}, 2'b10);
    chk("load_mem_addr", mem_addr, 32'h10);
    step(1);
    chk("load_rsp_valid", rsp_valid, 2'b01);
    chk("load_rsp_rdata", rsp_rdata, 32'hDEAD_BEEF);
    step(1);

    // Port 1 store then back-to-back load of the same address.
    set_req(1, 1'b1, 1'b1, 32'h20, 32'h1234_5678, 3'b010);
    #1 chk("store_ready", req_ready, 2'b10);
    step(1);
    set_req(1, 1'b1, 1'b0, 32'h20, 32'h0, 3'b010);
    #1 chk("store_mem_write", {mem_read, mem_write}, 2'b01);
    step(1);
    req_valid = 2'b00;
    #1 chk("store_ack_valid", rsp_valid, 2'b10);
    chk("store_ack_rdata", rsp_rdata, 32'h0);
    step(1);
    chk("load_back_valid", rsp_valid, 2'b10);
    chk("load_back_rdata", rsp_rdata, 32'h1234_5678);
    step(1);

    // Contention: both ports valid for six cycles.
    set_req(0, 1'b1, 1'b0, 32'h10, 32'h0, 3'b010);
    set_req(1, 1'b1, 1'b0, 32'h20, 32'h0, 3'b001);
    for (int i = 0; i < 6; i++) begin
`ifdef DMEM_ARB_RR_EN
      exp_g = (i % 2 == 0) ? 2'b01 : 2'b10;
`else
      exp_g = 2'b01;
`endif
      #1 chk("contention_grant", req_ready, exp_g);
      step(1);
    end
    req_valid = 2'b00;
    step(3);

    // Reset while a port-0 store is in its access cycle.
    set_req(0, 1'b1, 1'b1, 32'h30, 32'hCAFE_F00D, 3'b010);
    #1 chk("rst_acc_ready", req_ready, 2'b01);
    step(1);
    req_valid = 2'b00;
    rst = 1'b0;
    #1 chk("rst_acc_no_write", mem_write, 1'b0);
    step(1);
    rst = 1'b1;
    #1 chk("rst_acc_no_rsp", rsp_valid, 2'b00);
    chk("rst_acc_mem_kept", mem[12], 32'h0BAD_F00D);
    step(1);

    // Mixed traffic after reset: port 1 alone, then conflicts and a port-0 store.
    set_req(1, 1'b1, 1'b0, 32'h10, 32'h0, 3'b100);
    step(1);
    set_req(0, 1'b1, 1'b1, 32'h14, 32'h5555_AAAA, 3'b001);
    step(2);
    set_req(1, 1'b1, 1'b0, 32'h14, 32'h0, 3'b010);
    req_valid[0] = 1'b0;
    step(1);
    req_valid = 2'b00;
    step(4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
